// File: rtl/bmem_arbiter.sv
// ----------------------------------------------------------------------------
// bmem_arbiter
//   Arbitrates instruction-side line reads and data-side line reads/writes
//   onto a single burst memory port. One transaction is in flight at a time.
//   The line is BUS_WIDTH*BURST_LEN bits and moves as BURST_LEN beats.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_read, i_addr             I-side line read request (level) and address
//   i_rdata, i_resp            I-side returned line, one-cycle completion
//   d_read, d_write, d_addr    D-side line request (level) and address
//   d_wdata                    D-side write line, beat k at [k*BUS_WIDTH +: BUS_WIDTH]
//   d_rdata, d_resp            D-side returned line, one-cycle completion
//   mem_addr/read/write        registered burst command, held for the burst
//   mem_wdata                  current write beat
//   mem_rdata, mem_resp        beat data and per-beat valid from memory
//   error                      sticky protocol-error flag
//
// Configuration
//   BMEM_ARB_ROUND_ROBIN_EN    defined: ties go to the port not granted last.
//                              undefined: ties go to the D-side.
// ----------------------------------------------------------------------------
module bmem_arbiter #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_read,
    input  logic [31:0]                    i_addr,
    output logic [BUS_WIDTH*BURST_LEN-1:0] i_rdata,
    output logic                           i_resp,
    input  logic                           d_read,
    input  logic                           d_write,
    input  logic [31:0]                    d_addr,
    input  logic [BUS_WIDTH*BURST_LEN-1:0] d_wdata,
    output logic [BUS_WIDTH*BURST_LEN-1:0] d_rdata,
    output logic                           d_resp,
    output logic [31:0]                    mem_addr,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [BUS_WIDTH-1:0]           mem_wdata,
    input  logic [BUS_WIDTH-1:0]           mem_rdata,
    input  logic                           mem_resp,
    output logic                           error
);
    localparam int unsigned LINE_WIDTH = BUS_WIDTH * BURST_LEN;
    localparam int unsigned CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned OFF_W      = $clog2(LINE_WIDTH / 8);
    localparam logic [31:0] OFF_MASK   = 32'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    grant_d_q;      // 1: current transaction belongs to D-side
    logic [CNT_W-1:0]        beat_q;
    logic [31:0]             addr_q;
    logic [LINE_WIDTH-1:0]   line_q;         // write line, or read line under assembly
    logic [LINE_WIDTH-1:0]   line_beat;      // line_q with the incoming beat merged
    logic [LINE_WIDTH-1:0]   i_rdata_q, d_rdata_q;
    logic                    mem_read_q, mem_write_q, error_q;
    logic                    d_req, any_req, win_d, last_beat, err_set;
`ifdef BMEM_ARB_ROUND_ROBIN_EN
    logic                    last_d_q;       // last grant went to D-side
`endif

    assign d_req     = d_read | d_write;
    assign any_req   = i_read | d_req;
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        win_d = d_req;
        if (i_read && d_req) begin
`ifdef BMEM_ARB_ROUND_ROBIN_EN
            win_d = ~last_d_q;
`else
            win_d = 1'b1;
`endif
        end
    end

    // Simultaneous d_read/d_write is served as a read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (any_req) state_d = (win_d && d_write && !d_read) ? WRITE : READ;
            READ, WRITE: if (mem_resp && last_beat) state_d = DONE;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        line_beat = line_q;
        mem_wdata = '0;
        for (int unsigned k = 0; k < BURST_LEN; k++) begin
            if (beat_q == CNT_W'(k)) begin
                line_beat[k*BUS_WIDTH +: BUS_WIDTH] = mem_rdata;
                if (state_q == WRITE) mem_wdata = line_q[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign err_set = ((state_q == IDLE) && d_read && d_write) ||
                     (mem_resp && ((state_q == IDLE) || (state_q == DONE)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_d_q   <= 1'b0;
            beat_q      <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            error_q     <= 1'b0;
`ifdef BMEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_d_q   <= win_d;
                        beat_q      <= '0;
                        addr_q      <= (win_d ? d_addr : i_addr) & ~OFF_MASK;
                        mem_read_q  <= (state_d == READ);
                        mem_write_q <= (state_d == WRITE);
                        if (state_d == WRITE) line_q <= d_wdata;
`ifdef BMEM_ARB_ROUND_ROBIN_EN
                        last_d_q    <= win_d;
`endif
                    end
                end
                READ: begin
                    if (mem_resp) begin
                        line_q <= line_beat;
                        beat_q <= beat_q + 1'b1;
                        // Publish the completed line on the edge taking the last beat
                        // so it is already valid during the resp cycle.
                        if (last_beat) begin
                            mem_read_q <= 1'b0;
                            if (grant_d_q) d_rdata_q <= line_beat;
                            else           i_rdata_q <= line_beat;
                        end
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) mem_write_q <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (err_set) error_q <= 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_resp    = (state_q == DONE) && !grant_d_q;
    assign d_resp    = (state_q == DONE) &&  grant_d_q;
    assign error     = error_q;

endmodule
